// File: rtl/lc3b_types.sv
// Shared types for the L2 arbiter: bus widths, FSM states, grant owner and the
// forwarded Wishbone request payload.
package lc3b_types;

    localparam int unsigned WB_ADR_W = 12;
    localparam int unsigned WB_DAT_W = 128;
    localparam int unsigned WB_SEL_W = 16;
    localparam int unsigned WORD_W   = 16;

    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    // Master-driven half of a Wishbone transfer, muxed as one unit onto l2
    typedef struct packed {
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
        logic                we;
        logic                stb;
        logic                cyc;
    } wb_req_t;

endpackage

// File: rtl/wishbone.sv
// Classic Wishbone bundle shared by both cache requesters and the L2 port.
interface wishbone;
    import lc3b_types::*;

    logic [WB_ADR_W-1:0] ADR;
    logic [WB_DAT_W-1:0] DAT_M;
    logic [WB_DAT_W-1:0] DAT_S;
    logic [WB_SEL_W-1:0] SEL;
    logic                WE;
    logic                STB;
    logic                CYC;
    logic                ACK;

    modport master (output ADR, DAT_M, SEL, WE, STB, CYC, input DAT_S, ACK);
    modport slave  (input ADR, DAT_M, SEL, WE, STB, CYC, output DAT_S, ACK);

endinterface

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     inc,
    output lc3b_word count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WORD_W'(1);
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 Wishbone port between icache and dcache,
// with saturating per-requester wait-cycle counters.
module l2_arbiter
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset_n,
    wishbone.slave     icache,
    wishbone.slave     dcache,
    wishbone.master    l2,
    output lc3b_word   i_wait_count,
    output lc3b_word   d_wait_count,
    output arb_owner_t owner
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    arb_owner_t r_last_grant;
    arb_owner_t w_next_last_grant;
    logic       w_i_req;
    logic       w_d_req;
    logic       w_i_inc;
    logic       w_d_inc;
    wb_req_t    w_i_pay;
    wb_req_t    w_d_pay;
    wb_req_t    w_l2_pay;

    assign w_i_req = icache.CYC & icache.STB;
    assign w_d_req = dcache.CYC & dcache.STB;

    assign w_i_pay = '{adr: icache.ADR, dat: icache.DAT_M, sel: icache.SEL,
                       we: icache.WE, stb: icache.STB, cyc: icache.CYC};
    assign w_d_pay = '{adr: dcache.ADR, dat: dcache.DAT_M, sel: dcache.SEL,
                       we: dcache.WE, stb: dcache.STB, cyc: dcache.CYC};

    // State and fairness history; last_grant starts at D so icache wins the first tie
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= OWN_D;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // Every grant passes through IDLE, so back-to-back grants always see one idle cycle
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_next_state = (r_last_grant == OWN_I) ? ARB_SERVE_D : ARB_SERVE_I;
                end else if (w_i_req) begin
                    w_next_state = ARB_SERVE_I;
                end else if (w_d_req) begin
                    w_next_state = ARB_SERVE_D;
                end
            end
            ARB_SERVE_I: begin
                if (l2.ACK) begin
                    w_next_state      = ARB_IDLE;
                    w_next_last_grant = OWN_I;
                end else if (!icache.CYC) begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_SERVE_D: begin
                if (l2.ACK) begin
                    w_next_state      = ARB_IDLE;
                    w_next_last_grant = OWN_D;
                end else if (!dcache.CYC) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // Payload and ACK steering purely from state; an ACK seen in IDLE goes nowhere
    always_comb begin
        w_l2_pay   = '0;
        icache.ACK = 1'b0;
        dcache.ACK = 1'b0;
        owner      = OWN_NONE;
        unique case (r_state)
            ARB_SERVE_I: begin
                w_l2_pay   = w_i_pay;
                icache.ACK = l2.ACK;
                owner      = OWN_I;
            end
            ARB_SERVE_D: begin
                w_l2_pay   = w_d_pay;
                dcache.ACK = l2.ACK;
                owner      = OWN_D;
            end
            default: begin
                w_l2_pay = '0;
            end
        endcase
    end

    assign l2.ADR   = w_l2_pay.adr;
    assign l2.DAT_M = w_l2_pay.dat;
    assign l2.SEL   = w_l2_pay.sel;
    assign l2.WE    = w_l2_pay.we;
    assign l2.STB   = w_l2_pay.stb;
    assign l2.CYC   = w_l2_pay.cyc;

    assign icache.DAT_S = l2.DAT_S;
    assign dcache.DAT_S = l2.DAT_S;

    assign w_i_inc = w_i_req && (r_state != ARB_SERVE_I);
    assign w_d_inc = w_d_req && (r_state != ARB_SERVE_D);

    sat_counter16 u_i_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_i_inc),
        .count   (i_wait_count)
    );

    sat_counter16 u_d_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_d_inc),
        .count   (d_wait_count)
    );

endmodule

// File: tb/tb_l2_arbiter.sv
// Testbench for l2_arbiter: directed scenarios plus random traffic, all compared
// against a transaction-level grant model held in the bench.
module tb_l2_arbiter;
    import lc3b_types::*;

    logic       clk;
    logic       reset_n;
    lc3b_word   i_wait_count;
    lc3b_word   d_wait_count;
    arb_owner_t owner;

    wishbone ic_bus ();
    wishbone dc_bus ();
    wishbone l2_bus ();

    l2_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .icache       (ic_bus),
        .dcache       (dc_bus),
        .l2           (l2_bus),
        .i_wait_count (i_wait_count),
        .d_wait_count (d_wait_count),
        .owner        (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who holds the port (0 none, 1 icache, 2 dcache), who won last, wait counts
    int m_own;
    int m_last;
    int m_cnt [2];

    int  dut_ack [2];
    int  g_log [$];
    bit  ack_seen [2];
    bit  pending [2];
    logic [127:0] tb_dat_s;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rq_field(input int k, input int f);
        if (k == 0) begin
            case (f)
                0: return 128'(ic_bus.CYC);
                1: return 128'(ic_bus.STB);
                2: return 128'(ic_bus.WE);
                3: return 128'(ic_bus.SEL);
                4: return 128'(ic_bus.ADR);
                default: return ic_bus.DAT_M;
            endcase
        end
        case (f)
            0: return 128'(dc_bus.CYC);
            1: return 128'(dc_bus.STB);
            2: return 128'(dc_bus.WE);
            3: return 128'(dc_bus.SEL);
            4: return 128'(dc_bus.ADR);
            default: return dc_bus.DAT_M;
        endcase
    endfunction

    task automatic set_req(input int k, input bit cyc, input bit stb, input bit we,
                           input logic [11:0] adr, input logic [15:0] sel,
                           input logic [127:0] dat);
        if (k == 0) begin
            ic_bus.CYC = cyc; ic_bus.STB = stb; ic_bus.WE = we;
            ic_bus.ADR = adr; ic_bus.SEL = sel; ic_bus.DAT_M = dat;
        end else begin
            dc_bus.CYC = cyc; dc_bus.STB = stb; dc_bus.WE = we;
            dc_bus.ADR = adr; dc_bus.SEL = sel; dc_bus.DAT_M = dat;
        end
    endtask

    task automatic check_cycle();
        chk("owner", 128'(owner), 128'(m_own));
        if (m_own == 0) begin
            chk("l2_cyc_idle", 128'(l2_bus.CYC), 128'(0));
            chk("l2_stb_idle", 128'(l2_bus.STB), 128'(0));
            chk("l2_we_idle",  128'(l2_bus.WE),  128'(0));
            chk("l2_sel_idle", 128'(l2_bus.SEL), 128'(0));
        end else begin
            chk("l2_cyc", 128'(l2_bus.CYC), rq_field(m_own - 1, 0));
            chk("l2_stb", 128'(l2_bus.STB), rq_field(m_own - 1, 1));
            chk("l2_we",  128'(l2_bus.WE),  rq_field(m_own - 1, 2));
            chk("l2_sel", 128'(l2_bus.SEL), rq_field(m_own - 1, 3));
            chk("l2_adr", 128'(l2_bus.ADR), rq_field(m_own - 1, 4));
            chk("l2_dat", l2_bus.DAT_M,     rq_field(m_own - 1, 5));
        end
        chk("i_ack", 128'(ic_bus.ACK), 128'((m_own == 1) && l2_bus.ACK));
        chk("d_ack", 128'(dc_bus.ACK), 128'((m_own == 2) && l2_bus.ACK));
        chk("i_dat_s", ic_bus.DAT_S, tb_dat_s);
        chk("d_dat_s", dc_bus.DAT_S, tb_dat_s);
        chk("i_wait", 128'(i_wait_count), 128'(m_cnt[0]));
        chk("d_wait", 128'(d_wait_count), 128'(m_cnt[1]));
    endtask

    // Advance the model by one clock using the inputs present before the edge
    task automatic step_model();
        bit req [2];
        req[0] = ic_bus.CYC & ic_bus.STB;
        req[1] = dc_bus.CYC & dc_bus.STB;
        if (!reset_n) begin
            m_own = 0; m_last = 2; m_cnt[0] = 0; m_cnt[1] = 0;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (req[k] && (m_own != k + 1) && (m_cnt[k] < 65535)) m_cnt[k]++;
        end
        if (m_own == 0) begin
            if (req[0] && req[1]) m_own = (m_last == 1) ? 2 : 1;
            else if (req[0])      m_own = 1;
            else if (req[1])      m_own = 2;
        end else if (l2_bus.ACK) begin
            m_last = m_own;
            m_own  = 0;
        end else if (rq_field(m_own - 1, 0) == 128'(0)) begin
            m_own = 0;
        end
    endtask

    task automatic tick(input bit full);
        @(negedge clk);
        if (full) check_cycle();
        ack_seen[0] = (m_own == 1) && l2_bus.ACK;
        ack_seen[1] = (m_own == 2) && l2_bus.ACK;
        if (ic_bus.ACK) begin dut_ack[0]++; g_log.push_back(1); end
        if (dc_bus.ACK) begin dut_ack[1]++; g_log.push_back(2); end
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_req(0, 0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_own = 0; m_last = 2; m_cnt[0] = 0; m_cnt[1] = 0;
        dut_ack[0] = 0; dut_ack[1] = 0;
        pending[0] = 0; pending[1] = 0;
        g_log.delete();
        reset_n = 1'b1;
    endtask

    task automatic drive_random();
        for (int k = 0; k < 2; k++) begin
            if (pending[k] && ack_seen[k]) begin
                pending[k] = 0;
                set_req(k, 0, 0, 0, '0, '0, '0);
            end else if (pending[k] && ($urandom_range(0, 19) == 0)) begin
                pending[k] = 0;
                set_req(k, 0, 0, 0, '0, '0, '0);
            end else if (!pending[k] && ($urandom_range(0, 2) == 0)) begin
                pending[k] = 1;
                set_req(k, 1, 1, 1'($urandom), 12'($urandom), 16'($urandom),
                        {$urandom, $urandom, $urandom, $urandom});
            end
        end
        l2_bus.ACK = ($urandom_range(0, 2) == 0);
        tb_dat_s   = {$urandom, $urandom, $urandom, $urandom};
        l2_bus.DAT_S = tb_dat_s;
        reset_n = ($urandom_range(0, 249) != 0);
    endtask

    initial begin
        tb_dat_s     = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        l2_bus.DAT_S = tb_dat_s;
        do_reset();
        chk("rst_owner", 128'(owner), 128'(OWN_NONE));
        chk("rst_i_wait", 128'(i_wait_count), 128'(0));
        chk("rst_d_wait", 128'(d_wait_count), 128'(0));

        // icache alone reads 0x010, L2 acks three cycles after CYC rises
        set_req(0, 1, 1, 0, 12'h010, 16'hFFFF, '0);
        tick(1);
        chk("s1_l2_cyc_c1", 128'(l2_bus.CYC), 128'(1));
        chk("s1_l2_adr_c1", 128'(l2_bus.ADR), 128'(12'h010));
        tick(1); tick(1); tick(1);
        l2_bus.ACK = 1'b1;
        tick(1);
        set_req(0, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b0;
        tick(1);
        chk("s1_i_ack_n", 128'(dut_ack[0]), 128'(1));
        chk("s1_d_ack_n", 128'(dut_ack[1]), 128'(0));
        chk("s1_owner_end", 128'(owner), 128'(OWN_NONE));

        // both request from reset: icache first, dcache after one idle cycle
        do_reset();
        set_req(0, 1, 1, 0, 12'h100, 16'hFFFF, '0);
        set_req(1, 1, 1, 0, 12'h200, 16'hFFFF, '0);
        tick(1); tick(1); tick(1);
        l2_bus.ACK = 1'b1;
        tick(1);
        set_req(0, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b0;
        tick(1);
        chk("s2_owner_d", 128'(owner), 128'(OWN_D));
        chk("s2_d_wait", 128'(d_wait_count), 128'(3 + 2));
        l2_bus.ACK = 1'b1;
        tick(1);
        set_req(1, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b0;
        tick(1);

        // continuous contention: grants alternate I, D, I, D
        do_reset();
        set_req(0, 1, 1, 0, 12'h011, 16'hFFFF, '0);
        set_req(1, 1, 1, 0, 12'h022, 16'hFFFF, '0);
        l2_bus.ACK = 1'b1;
        for (int c = 0; c < 40 && g_log.size() < 4; c++) tick(1);
        chk("s3_grants", 128'(g_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < g_log.size(); i++)
            chk("s3_order", 128'(g_log[i]), 128'((i % 2 == 0) ? 1 : 2));
        l2_bus.ACK = 1'b0;
        set_req(0, 0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0, '0);
        tick(1);

        // dcache write forwarded verbatim while icache waits
        do_reset();
        set_req(1, 1, 1, 1, 12'h2A5, 16'h0030, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D);
        tick(1);
        set_req(0, 1, 1, 0, 12'h040, 16'hFFFF, '0);
        chk("s4_we",  128'(l2_bus.WE),  128'(1));
        chk("s4_sel", 128'(l2_bus.SEL), 128'(16'h0030));
        chk("s4_adr", 128'(l2_bus.ADR), 128'(12'h2A5));
        chk("s4_dat", l2_bus.DAT_M, 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D);
        tick(1); tick(1);
        chk("s4_i_waits", 128'(owner), 128'(OWN_D));
        l2_bus.ACK = 1'b1;
        tick(1);
        set_req(1, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b0;
        tick(1);
        chk("s4_i_after", 128'(owner), 128'(OWN_I));
        l2_bus.ACK = 1'b1;
        tick(1);
        set_req(0, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b0;
        tick(1);

        // abort keeps last_grant; reset mid-dcache drops l2 and clears counters
        do_reset();
        set_req(0, 1, 1, 0, 12'h001, 16'hFFFF, '0);
        tick(1);
        l2_bus.ACK = 1'b1;
        tick(1);
        set_req(0, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b0;
        tick(1);
        set_req(1, 1, 1, 0, 12'h002, 16'hFFFF, '0);
        tick(1);
        set_req(1, 0, 0, 0, '0, '0, '0);
        tick(1);
        chk("s5_abort_idle", 128'(owner), 128'(OWN_NONE));
        set_req(0, 1, 1, 0, 12'h003, 16'hFFFF, '0);
        set_req(1, 1, 1, 0, 12'h004, 16'hFFFF, '0);
        tick(1);
        chk("s5_rr_kept", 128'(owner), 128'(OWN_D));
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        set_req(0, 0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0, '0);
        l2_bus.ACK = 1'b1;
        chk("s5_rst_cyc", 128'(l2_bus.CYC), 128'(0));
        chk("s5_rst_iw", 128'(i_wait_count), 128'(0));
        chk("s5_rst_dw", 128'(d_wait_count), 128'(0));
        tick(1);
        l2_bus.ACK = 1'b0;

        // icache starved behind a never-acked dcache transfer: counter must saturate
        do_reset();
        set_req(1, 1, 1, 0, 12'h0F0, 16'hFFFF, '0);
        tick(1);
        set_req(0, 1, 1, 0, 12'h0F1, 16'hFFFF, '0);
        for (int n = 0; n < 70000; n++) tick((m_cnt[0] >= 65532) && (m_cnt[0] <= 65535) && (n < 65545));
        tick(1);
        chk("s6_i_sat", 128'(i_wait_count), 128'(16'hFFFF));
        chk("s6_d_wait", 128'(d_wait_count), 128'(1));

        // random traffic including late ACKs, aborts and occasional resets
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            drive_random();
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port icache, wishbone.slave (ADR 12b, DAT_M/DAT_S 128b, SEL 16b, WE, STB, CYC, ACK): instruction-side miss requester.
REQ-004 SHALL have port dcache, wishbone.slave (same widths): data-side miss requester.
REQ-005 SHALL have port l2, wishbone.master (same widths): shared downstream L2/memory port.
REQ-006 SHALL have port i_wait_count, output, lc3b_word: cycles icache requested but was not granted.
REQ-007 SHALL have port d_wait_count, output, lc3b_word: cycles dcache requested but was not granted.
REQ-008 SHALL have port owner, output, arb_owner_t: current grant, for debug and counter_control.

Function
REQ-009 SHALL define request per requester as CYC & STB.
REQ-010 SHALL implement FSM states ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D.
REQ-011 SHALL, in ARB_IDLE with exactly one request, move to that requester's SERVE state at the next edge.
REQ-012 SHALL, in ARB_IDLE with both requesting, grant the requester not recorded in last_grant (round-robin).
REQ-013 SHALL, in ARB_IDLE with no request, remain in ARB_IDLE.
REQ-014 SHALL, in ARB_SERVE_x, drive l2 ADR/DAT_M/SEL/WE/STB/CYC combinationally from the granted requester only.
REQ-015 SHALL, in ARB_IDLE, drive l2 STB=CYC=WE=0, SEL=0.
REQ-016 SHALL route l2.DAT_S to both requesters' DAT_S unconditionally.
REQ-017 SHALL route l2.ACK only to the granted requester; the non-granted requester ACK=0 always.
REQ-018 SHALL, on l2.ACK in ARB_SERVE_x, return to ARB_IDLE at the next edge and set last_grant to x.
REQ-019 SHALL, if the granted requester drops CYC before ACK (abort), return to ARB_IDLE at the next edge without updating last_grant.
REQ-020 SHALL insert exactly one ARB_IDLE cycle between consecutive grants; arbitration latency is 1 cycle from request to l2.CYC.
REQ-021 SHALL increment i_wait_count (d_wait_count) each cycle icache (dcache) requests and FSM is not in its SERVE state, including the arbitration cycle.
REQ-022 SHALL saturate both wait counters at 16'hFFFF; no wrap.
REQ-023 SHALL drive owner = OWN_NONE / OWN_I / OWN_D matching the FSM state.

Reset
REQ-024 SHALL, on reset_n=0 at an edge, set state ARB_IDLE, last_grant OWN_D (icache wins first tie), both counters 0.
REQ-025 SHALL, on reset mid-transaction, drop l2 CYC/STB from the cycle after the reset edge; a late l2.ACK in ARB_IDLE is ignored and forwarded to no one.

Structure
REQ-026 SHALL declare arb_state_t and arb_owner_t (OWN_NONE, OWN_I, OWN_D) in lc3b_types.
REQ-027 SHALL instantiate sub-module sat_counter16 (clk, reset_n, inc, count) twice for the wait counters.
REQ-028 SHALL contain no storage of request payload; all forwarding is combinational from state.

Verification
REQ-029 SHALL cover: icache alone reads ADR=12'h010, l2 ACKs 3 cycles later -> l2.CYC at cycle 1, icache.ACK once, dcache.ACK=0, owner OWN_I then OWN_NONE.
REQ-030 SHALL cover: both request from reset -> icache served first, then dcache after one idle cycle; d_wait_count = (icache service cycles + 2).
REQ-031 SHALL cover: both request continuously for 4 transactions -> grants alternate I, D, I, D.
REQ-032 SHALL cover: dcache write (WE=1, SEL=16'h0030, DAT_M pattern) -> l2 sees identical WE/SEL/DAT_M/ADR; icache request during it waits.
REQ-033 SHALL cover: granted icache drops CYC before ACK -> ARB_IDLE next cycle, last_grant unchanged; reset_n=0 mid-dcache transaction -> l2.CYC=0 next cycle, counters 0.
REQ-034 SHALL cover: icache held waiting 70000 cycles -> i_wait_count stays 16'hFFFF.
